hop_input_sel: RTL and testbench
================================

Name: hop_input_sel

Overview:
- Downstream consumer of the fk state flags, response counters and fk_chg_p from the fk control stage.
- On each fk_chg_p it selects the hop mode for the upcoming slot and snapshots the relevant native, estimated or master clock.
- It then builds the hop-kernel input vector (X, Y1, Y2, A–E), handshakes it into the shared hop kernel and returns the resulting RF channel to the PLL programming logic before the slot boundary.

Parameters:
- KOFF_A, 24, koffset used when koffset_sel=0 (A-train).
- KOFF_B, 8, koffset used when koffset_sel=1 (B-train).

Ports:
- clk_6M  in  1  system clock.
- rstz  in  1  asynchronous active-low reset.
- fk_chg_p  in  1  one-cycle hop-compute request.
- fk_pstxid, fk_psrxfhs, fk_psackfhs, fk_connsnewslave, fk_pagetxfhs, fk_pagerxackfhs, fk_connsnewmaster  in  1 each  next-slot state flags.
- ps, page, conns  in  1 each  current link state; fallback when no fk flag is set.
- CLKN, CLKE, CLK  in  28 each  native, estimated and piconet clocks.
- counter_clkN1  in  6  slave response N.
- counter_clkE1  in  5  master response N.
- koffset_sel  in  1  train select.
- addr_page  in  28  {UAP[3:0],LAP[23:0]} of the paged or own device.
- addr_conn  in  28  master address for connection hopping.
- hk_ack  in  1  kernel result valid.
- hk_chan  in  7  kernel channel, 0..78.
- ovr_clr  in  1  clears fk_overrun.
- hk_req  out  1  kernel request.
- hk_x  out  5.
- hk_y1  out  1.
- hk_y2  out  6.
- hk_a  out  5.
- hk_b  out  4.
- hk_c  out  5.
- hk_d  out  9.
- hk_e  out  7.
- hk_conn  out  1  tells the kernel to apply the connection F term.
- fk_chan  out  7  latched channel.
- fk_chan_vld  out  1  one-cycle pulse.
- fk_busy  out  1  high while not IDLE.
- fk_overrun  out  1  sticky.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, freeze registers 0.
- Mode priority, sampled in the fk_chg_p cycle: pstxid/psrxfhs/psackfhs → SRSP; pagetxfhs/pagerxackfhs → MRSP; connsnewslave/connsnewmaster → CONN. With no fk flag set: ps → PSCAN, page → PAGE, conns → CONN, otherwise IDLE (no request issued).
- Next-tick clock: ck = sampled clock + 1, modulo 2^28. CLKN is used for SRSP and PSCAN, CLKE for MRSP and PAGE, CLK for CONN.
- Freeze: frzN[4:0] loads ckN[16:12] when SRSP is selected and the previous mode was not SRSP. frzE is handled the same way for MRSP using ckE.
- X selection, all arithmetic mod 32:
  - PSCAN: ck[16:12].
  - PAGE: ck[16:12] + koff + ({ck[4:2],ck[0]} − ck[16:12] mod 16).
  - SRSP: frzN + counter_clkN1[4:0].
  - MRSP: frzE + koff + ({ck[4:2],ck[0]} − frzE mod 16) + counter_clkE1.
  - CONN: ck[6:2].
- Y1: ck[1] in all modes. Y2 = {Y1,5'b0}.
- Address terms in non-CONN modes, taken from addr_page:
  - A = a[27:23]
  - B = a[22:19]
  - C = a[8,6,4,2,0]
  - D = a[18:10]
  - E = a[13,11,9,7,5,3,1]
- Address terms in CONN mode, taken from addr_conn: A ^= ck[25:21], C ^= ck[20:16], D ^= ck[15:7]. hk_conn = 1.
- FSM:
  - IDLE: fk_chg_p with a valid mode → CALC.
  - CALC: registers all hk_* inputs (1 cycle) → REQ.
  - REQ: hk_req = 1, inputs held stable, until hk_ack → DONE.
  - DONE: latches fk_chan = hk_chan and pulses fk_chan_vld → IDLE.
- Latency: fk_chg_p → hk_req is 2 cycles. hk_ack → fk_chan_vld is 1 cycle.
- fk_chg_p while not IDLE: request dropped, fk_overrun set. ovr_clr clears it; ovr_clr and a new overrun in the same cycle leave it set.
- hk_ack outside REQ is ignored. hk_chan > 78 is latched unchanged.
- fk_chan holds its value until the next DONE.
- rstz low mid-handshake: immediate return to IDLE, hk_req drops.

Decomposition:
- Shared package holds the mode enum {IDLE,PSCAN,PAGE,SRSP,MRSP,CONN}, KOFF constants and address bit-slice constants.
- Natural sub-module: hop_x_calc, combinational X/Y1 computation from mode, ck, freeze value, N and koff.

Test Plan:
- PSCAN, CLKN=28'h000_F000 → ck[16:12]=5'h0F, hk_x=15, Y1=0; hk_ack on the 3rd REQ cycle with hk_chan=42 → fk_chan=42, one fk_chan_vld pulse.
- SRSP entry with CLKN[16:12]=30, then counter_clkN1 = 1, 2, 3 on successive fk_chg_p → hk_x = 31, 0, 1 (wrap); frzN is not reloaded.
- PAGE, koffset_sel=0, CLKE=28'h0000_00C → ck=13, ck[16:12]=0, {ck[4:2],ck[0]}=7 → hk_x=31. With koffset_sel=1 → hk_x=15.
- CONN, CLK=28'hFFF_FFFF → ck wraps to 0 → hk_x=0, Y1=0, A=addr_conn[27:23], hk_conn=1.
- fk_chg_p during REQ → fk_overrun=1, no second hk_req; ovr_clr → 0.
- rstz pulsed low while hk_req=1 → hk_req, fk_busy, fk_chan all 0; the next fk_chg_p completes normally.

Source files
------------

// File: rtl/hop_input_sel_pkg.sv
// Shared types and constants for the hop-input selection block: hop modes,
// default train offsets and the address bit positions feeding the hop kernel.
package hop_input_sel_pkg;

    typedef enum logic [2:0] {
        ModeIdle  = 3'd0,
        ModePscan = 3'd1,
        ModePage  = 3'd2,
        ModeSrsp  = 3'd3,
        ModeMrsp  = 3'd4,
        ModeConn  = 3'd5
    } hop_mode_e;

    localparam int unsigned KoffADefault = 24;
    localparam int unsigned KoffBDefault = 8;

    localparam int unsigned AMsb = 27;
    localparam int unsigned ALsb = 23;
    localparam int unsigned BMsb = 22;
    localparam int unsigned BLsb = 19;
    localparam int unsigned DMsb = 18;
    localparam int unsigned DLsb = 10;

    // C and E interleave the even and odd low address bits respectively.
    function automatic logic [4:0] addr_c(input logic [27:0] a);
        return {a[8], a[6], a[4], a[2], a[0]};
    endfunction

    function automatic logic [6:0] addr_e(input logic [27:0] a);
        return {a[13], a[11], a[9], a[7], a[5], a[3], a[1]};
    endfunction

endpackage

// File: rtl/hop_input_sel_x_calc.sv
// Combinational X/Y1 selection for the hop kernel, from the captured mode, the
// relevant clock fields, the frozen clock value, the response count and koffset.
module hop_x_calc
    import hop_input_sel_pkg::*;
(
    input  hop_mode_e   mode,
    input  logic [4:0]  ck_hi,
    input  logic [6:0]  ck_lo,
    input  logic [4:0]  frz,
    input  logic [4:0]  n,
    input  logic [4:0]  koff,
    output logic [4:0]  x,
    output logic        y1
);

    logic [3:0] phase;
    logic [4:0] base;
    logic [4:0] diff;
    logic [3:0] offs;

    // Train phase offset: ({ck[4:2],ck[0]} - base) mod 16.
    assign phase = {ck_lo[4:2], ck_lo[0]};
    assign base  = (mode == ModeMrsp) ? frz : ck_hi;
    assign diff  = {1'b0, phase} - base;
    assign offs  = diff[3:0];
    assign y1    = ck_lo[1];

    always_comb begin
        x = '0;
        unique case (mode)
            ModePscan: x = ck_hi;
            ModePage:  x = ck_hi + koff + {1'b0, offs};
            ModeSrsp:  x = frz + n;
            ModeMrsp:  x = frz + koff + {1'b0, offs} + n;
            ModeConn:  x = ck_lo[6:2];
            default:   x = '0;
        endcase
    end

endmodule

// File: rtl/hop_input_sel.sv
// Selects the hop mode on each fk_chg_p, builds the hop-kernel input vector,
// handshakes it into the shared kernel and latches the returned RF channel.
module hop_input_sel
    import hop_input_sel_pkg::*;
#(
    parameter int unsigned KOFF_A = KoffADefault,
    parameter int unsigned KOFF_B = KoffBDefault
) (
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        fk_chg_p,
    input  logic        fk_pstxid,
    input  logic        fk_psrxfhs,
    input  logic        fk_psackfhs,
    input  logic        fk_connsnewslave,
    input  logic        fk_pagetxfhs,
    input  logic        fk_pagerxackfhs,
    input  logic        fk_connsnewmaster,
    input  logic        ps,
    input  logic        page,
    input  logic        conns,
    input  logic [27:0] CLKN,
    input  logic [27:0] CLKE,
    input  logic [27:0] CLK,
    input  logic [5:0]  counter_clkN1,
    input  logic [4:0]  counter_clkE1,
    input  logic        koffset_sel,
    input  logic [27:0] addr_page,
    input  logic [27:0] addr_conn,
    input  logic        hk_ack,
    input  logic [6:0]  hk_chan,
    input  logic        ovr_clr,
    output logic        hk_req,
    output logic [4:0]  hk_x,
    output logic        hk_y1,
    output logic [5:0]  hk_y2,
    output logic [4:0]  hk_a,
    output logic [3:0]  hk_b,
    output logic [4:0]  hk_c,
    output logic [8:0]  hk_d,
    output logic [6:0]  hk_e,
    output logic        hk_conn,
    output logic [6:0]  fk_chan,
    output logic        fk_chan_vld,
    output logic        fk_busy,
    output logic        fk_overrun
);

    typedef enum logic [1:0] {StIdle, StCalc, StReq, StDone} state_e;

    state_e     state_q, state_d;
    hop_mode_e  mode_sel, mode_q, prev_mode_q;
    logic [27:0] ck_n, ck_e, ck_c, ck_sel;
    logic [25:0] ck_q;
    logic [4:0]  frz_n_q, frz_e_q, n_q, koff_q;
    logic [27:0] addr_q;
    logic        start;
    logic        ovr_q, ovr_d;
    logic [4:0]  x_calc;
    logic        y1_calc;
    logic [4:0]  hk_x_q, hk_a_q, hk_c_q;
    logic        hk_y1_q, hk_conn_q;
    logic [3:0]  hk_b_q;
    logic [8:0]  hk_d_q;
    logic [6:0]  hk_e_q, fk_chan_q;
    logic        unused_bits;

    assign ck_n = CLKN + 28'd1;
    assign ck_e = CLKE + 28'd1;
    assign ck_c = CLK + 28'd1;
    assign unused_bits = ^{counter_clkN1[5], ck_sel[27:26]};

    always_comb begin
        mode_sel = ModeIdle;
        if (fk_pstxid || fk_psrxfhs || fk_psackfhs)            mode_sel = ModeSrsp;
        else if (fk_pagetxfhs || fk_pagerxackfhs)              mode_sel = ModeMrsp;
        else if (fk_connsnewslave || fk_connsnewmaster)        mode_sel = ModeConn;
        else if (ps)                                           mode_sel = ModePscan;
        else if (page)                                         mode_sel = ModePage;
        else if (conns)                                        mode_sel = ModeConn;
    end

    always_comb begin
        ck_sel = '0;
        unique case (mode_sel)
            ModeSrsp, ModePscan: ck_sel = ck_n;
            ModeMrsp, ModePage:  ck_sel = ck_e;
            ModeConn:            ck_sel = ck_c;
            default:             ck_sel = '0;
        endcase
    end

    assign start = fk_chg_p && (state_q == StIdle) && (mode_sel != ModeIdle);

    hop_x_calc u_x_calc (
        .mode  (mode_q),
        .ck_hi (ck_q[16:12]),
        .ck_lo (ck_q[6:0]),
        .frz   ((mode_q == ModeSrsp) ? frz_n_q : frz_e_q),
        .n     (n_q),
        .koff  (koff_q),
        .x     (x_calc),
        .y1    (y1_calc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StCalc;
            StCalc:  state_d = StReq;
            StReq:   if (hk_ack) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A fresh overrun wins over a simultaneous clear.
    always_comb begin
        ovr_d = ovr_q;
        if (ovr_clr) ovr_d = 1'b0;
        if (fk_chg_p && (state_q != StIdle)) ovr_d = 1'b1;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q     <= StIdle;
            mode_q      <= ModeIdle;
            prev_mode_q <= ModeIdle;
            ck_q        <= '0;
            frz_n_q     <= '0;
            frz_e_q     <= '0;
            n_q         <= '0;
            koff_q      <= '0;
            addr_q      <= '0;
            hk_x_q      <= '0;
            hk_y1_q     <= 1'b0;
            hk_a_q      <= '0;
            hk_b_q      <= '0;
            hk_c_q      <= '0;
            hk_d_q      <= '0;
            hk_e_q      <= '0;
            hk_conn_q   <= 1'b0;
            fk_chan_q   <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            ovr_q   <= ovr_d;
            if (fk_chg_p && (state_q == StIdle)) begin
                prev_mode_q <= mode_sel;
            end
            if (start) begin
                mode_q <= mode_sel;
                ck_q   <= ck_sel[25:0];
                n_q    <= (mode_sel == ModeSrsp) ? counter_clkN1[4:0] : counter_clkE1;
                koff_q <= koffset_sel ? 5'(KOFF_B) : 5'(KOFF_A);
                addr_q <= (mode_sel == ModeConn) ? addr_conn : addr_page;
                if (mode_sel == ModeSrsp && prev_mode_q != ModeSrsp) frz_n_q <= ck_n[16:12];
                if (mode_sel == ModeMrsp && prev_mode_q != ModeMrsp) frz_e_q <= ck_e[16:12];
            end
            if (state_q == StCalc) begin
                hk_x_q    <= x_calc;
                hk_y1_q   <= y1_calc;
                hk_b_q    <= addr_q[BMsb:BLsb];
                hk_e_q    <= addr_e(addr_q);
                hk_conn_q <= (mode_q == ModeConn);
                if (mode_q == ModeConn) begin
                    hk_a_q <= addr_q[AMsb:ALsb] ^ ck_q[25:21];
                    hk_c_q <= addr_c(addr_q) ^ ck_q[20:16];
                    hk_d_q <= addr_q[DMsb:DLsb] ^ ck_q[15:7];
                end else begin
                    hk_a_q <= addr_q[AMsb:ALsb];
                    hk_c_q <= addr_c(addr_q);
                    hk_d_q <= addr_q[DMsb:DLsb];
                end
            end
            if (state_q == StReq && hk_ack) begin
                fk_chan_q <= hk_chan;
            end
        end
    end

    assign hk_req      = (state_q == StReq);
    assign fk_busy     = (state_q != StIdle);
    assign fk_chan_vld = (state_q == StDone);
    assign fk_overrun  = ovr_q;
    assign fk_chan     = fk_chan_q;
    assign hk_x        = hk_x_q;
    assign hk_y1       = hk_y1_q;
    assign hk_y2       = {hk_y1_q, 5'b0};
    assign hk_a        = hk_a_q;
    assign hk_b        = hk_b_q;
    assign hk_c        = hk_c_q;
    assign hk_d        = hk_d_q;
    assign hk_e        = hk_e_q;
    assign hk_conn     = hk_conn_q;

endmodule

// File: tb/tb_hop_input_sel.sv
// Directed self-checking bench for hop_input_sel.
module tb_hop_input_sel;

    logic        clk_6M = 1'b0;
    logic        rstz;
    logic        fk_chg_p;
    logic        fk_pstxid, fk_psrxfhs, fk_psackfhs, fk_connsnewslave;
    logic        fk_pagetxfhs, fk_pagerxackfhs, fk_connsnewmaster;
    logic        ps, page, conns;
    logic [27:0] CLKN, CLKE, CLK;
    logic [5:0]  counter_clkN1;
    logic [4:0]  counter_clkE1;
    logic        koffset_sel;
    logic [27:0] addr_page, addr_conn;
    logic        hk_ack;
    logic [6:0]  hk_chan;
    logic        ovr_clr;
    logic        hk_req;
    logic [4:0]  hk_x;
    logic        hk_y1;
    logic [5:0]  hk_y2;
    logic [4:0]  hk_a;
    logic [3:0]  hk_b;
    logic [4:0]  hk_c;
    logic [8:0]  hk_d;
    logic [6:0]  hk_e;
    logic        hk_conn;
    logic [6:0]  fk_chan;
    logic        fk_chan_vld, fk_busy, fk_overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk_6M = ~clk_6M;

    hop_input_sel dut (
        .clk_6M            (clk_6M),
        .rstz              (rstz),
        .fk_chg_p          (fk_chg_p),
        .fk_pstxid         (fk_pstxid),
        .fk_psrxfhs        (fk_psrxfhs),
        .fk_psackfhs       (fk_psackfhs),
        .fk_connsnewslave  (fk_connsnewslave),
        .fk_pagetxfhs      (fk_pagetxfhs),
        .fk_pagerxackfhs   (fk_pagerxackfhs),
        .fk_connsnewmaster (fk_connsnewmaster),
        .ps                (ps),
        .page              (page),
        .conns             (conns),
        .CLKN              (CLKN),
        .CLKE              (CLKE),
        .CLK               (CLK),
        .counter_clkN1     (counter_clkN1),
        .counter_clkE1     (counter_clkE1),
        .koffset_sel       (koffset_sel),
        .addr_page         (addr_page),
        .addr_conn         (addr_conn),
        .hk_ack            (hk_ack),
        .hk_chan           (hk_chan),
        .ovr_clr           (ovr_clr),
        .hk_req            (hk_req),
        .hk_x              (hk_x),
        .hk_y1             (hk_y1),
        .hk_y2             (hk_y2),
        .hk_a              (hk_a),
        .hk_b              (hk_b),
        .hk_c              (hk_c),
        .hk_d              (hk_d),
        .hk_e              (hk_e),
        .hk_conn           (hk_conn),
        .fk_chan           (fk_chan),
        .fk_chan_vld       (fk_chan_vld),
        .fk_busy           (fk_busy),
        .fk_overrun        (fk_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_flags();
        fk_pstxid = 0; fk_psrxfhs = 0; fk_psackfhs = 0; fk_connsnewslave = 0;
        fk_pagetxfhs = 0; fk_pagerxackfhs = 0; fk_connsnewmaster = 0;
        ps = 0; page = 0; conns = 0;
    endtask

    // Pulse fk_chg_p and return at the first negedge with hk_req expected high.
    task automatic start_req(input string tag);
        @(negedge clk_6M);
        fk_chg_p = 1;
        @(negedge clk_6M);
        fk_chg_p = 0;
        chk({tag, "_req_calc"}, hk_req, 0);
        chk({tag, "_busy"}, fk_busy, 1);
        @(negedge clk_6M);
        chk({tag, "_req"}, hk_req, 1);
    endtask

    task automatic finish_ack(input string tag, input logic [6:0] chan);
        hk_ack = 1;
        hk_chan = chan;
        @(negedge clk_6M);
        hk_ack = 0;
        chk({tag, "_vld"}, fk_chan_vld, 1);
        chk({tag, "_chan"}, fk_chan, chan);
        @(negedge clk_6M);
        chk({tag, "_vld_low"}, fk_chan_vld, 0);
        chk({tag, "_idle"}, fk_busy, 0);
    endtask

    initial begin
        logic seen;
        rstz = 0; fk_chg_p = 0; clr_flags();
        CLKN = '0; CLKE = '0; CLK = '0;
        counter_clkN1 = '0; counter_clkE1 = '0; koffset_sel = 0;
        addr_page = 28'hF902BFF; addr_conn = 28'hABCDEF0;
        hk_ack = 0; hk_chan = '0; ovr_clr = 0;
        repeat (2) @(negedge clk_6M);
        chk("rst_req", hk_req, 0);
        chk("rst_busy", fk_busy, 0);
        chk("rst_chan", fk_chan, 0);
        chk("rst_vld", fk_chan_vld, 0);
        chk("rst_ovr", fk_overrun, 0);
        chk("rst_x", hk_x, 0);
        rstz = 1;

        // PSCAN: ck = 0x000F001
        ps = 1; CLKN = 28'h000F000;
        start_req("pscan");
        chk("pscan_x", hk_x, 15);
        chk("pscan_y1", hk_y1, 0);
        chk("pscan_a", hk_a, 31);
        chk("pscan_b", hk_b, 2);
        chk("pscan_c", hk_c, 31);
        chk("pscan_d", hk_d, 10);
        chk("pscan_e", hk_e, 127);
        chk("pscan_conn", hk_conn, 0);
        repeat (2) @(negedge clk_6M);
        chk("pscan_req3", hk_req, 1);
        finish_ack("pscan", 7'd42);

        // SRSP: freeze 30 via carry from CLKN+1, later CLKN changes must not reload
        clr_flags(); fk_pstxid = 1;
        CLKN = 28'h001DFFF; counter_clkN1 = 6'd1;
        start_req("srsp1");
        chk("srsp1_x", hk_x, 31);
        finish_ack("srsp1", 7'd3);
        CLKN = 28'h0005000; counter_clkN1 = 6'd2;
        start_req("srsp2");
        chk("srsp2_x", hk_x, 0);
        finish_ack("srsp2", 7'd4);
        counter_clkN1 = 6'h23;
        start_req("srsp3");
        chk("srsp3_x", hk_x, 1);
        finish_ack("srsp3", 7'd5);

        // PAGE: ck = 13, phase 7
        clr_flags(); page = 1; CLKE = 28'h000000C; koffset_sel = 0;
        start_req("page_a");
        chk("page_a_x", hk_x, 31);
        chk("page_a_y1", hk_y1, 0);
        finish_ack("page_a", 7'd10);
        koffset_sel = 1;
        start_req("page_b");
        chk("page_b_x", hk_x, 15);
        finish_ack("page_b", 7'd11);

        // MRSP: ck = 0x3007, frzE = 3, phase 3, 3+24+0+5 = 0 mod 32, Y1 = 1
        clr_flags(); fk_pagetxfhs = 1; CLKE = 28'h0003006; koffset_sel = 0;
        counter_clkE1 = 5'd5;
        start_req("mrsp");
        chk("mrsp_x", hk_x, 0);
        chk("mrsp_y1", hk_y1, 1);
        chk("mrsp_y2", hk_y2, 32);
        finish_ack("mrsp", 7'd12);

        // CONN: ck wraps to 0
        clr_flags(); conns = 1; CLK = 28'hFFFFFFF;
        start_req("conn");
        chk("conn_x", hk_x, 0);
        chk("conn_y1", hk_y1, 0);
        chk("conn_a", hk_a, 21);
        chk("conn_b", hk_b, 7);
        chk("conn_hkconn", hk_conn, 1);

        // Overrun during REQ, then clear racing a new overrun
        fk_chg_p = 1;
        @(negedge clk_6M);
        fk_chg_p = 0;
        chk("ovr_set", fk_overrun, 1);
        chk("ovr_req_held", hk_req, 1);
        fk_chg_p = 1; ovr_clr = 1;
        @(negedge clk_6M);
        fk_chg_p = 0; ovr_clr = 0;
        chk("ovr_clr_race", fk_overrun, 1);
        finish_ack("conn", 7'd100);
        seen = 0;
        repeat (4) begin
            @(negedge clk_6M);
            seen |= hk_req;
        end
        chk("ovr_no_second_req", seen, 0);
        ovr_clr = 1;
        @(negedge clk_6M);
        ovr_clr = 0;
        chk("ovr_cleared", fk_overrun, 0);

        // Ack outside REQ ignored
        hk_ack = 1; hk_chan = 7'd5;
        @(negedge clk_6M);
        hk_ack = 0;
        chk("stray_ack_vld", fk_chan_vld, 0);
        chk("stray_ack_chan", fk_chan, 100);
        chk("stray_ack_busy", fk_busy, 0);

        // Reset mid-handshake
        clr_flags(); ps = 1; CLKN = 28'h000F000;
        start_req("rst_mid");
        rstz = 0;
        #1;
        chk("rst_mid_req", hk_req, 0);
        chk("rst_mid_busy", fk_busy, 0);
        chk("rst_mid_chan", fk_chan, 0);
        @(negedge clk_6M);
        rstz = 1;
        start_req("post_rst");
        chk("post_rst_x", hk_x, 15);
        finish_ack("post_rst", 7'd77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
